// File: rtl/keypoint_pkg.sv
// Types and constants shared by the keypoint UART loader and its transmit-side twin.
package keypoint_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_UPPER = 2'd1,
        WAIT_LOWER = 2'd2,
        WRITE      = 2'd3
    } kp_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam int BYTES_PER_WORD          = 2;
    localparam int DEFAULT_CLOCKS_PER_BAUD = 50;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised line, mid-bit sampling, one-cycle valid/err strobes.
module uart_rx
    import keypoint_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
    input  logic       clk,
    input  logic       rst_in,
    input  logic       rx,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       err_o
);

    localparam int CNT_W = $clog2(CLOCKS_PER_BAUD + 1);
    localparam int HALF  = CLOCKS_PER_BAUD / 2;

    rx_state_t        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;

    // Idle-high synchroniser; rx_prev gives the falling-edge reference.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state    <= RX_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            data_o   <= '0;
            valid_o  <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            case (state)
                RX_IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (rx_prev && !rx_sync)
                        state <= RX_START;
                end
                // A low pulse shorter than half a bit is treated as noise.
                RX_START: begin
                    if (baud_cnt == CNT_W'(HALF - 1)) begin
                        baud_cnt <= '0;
                        state    <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (baud_cnt == CNT_W'(CLOCKS_PER_BAUD - 1)) begin
                        baud_cnt <= '0;
                        shift    <= {rx_sync, shift[7:1]};
                        if (bit_idx == 3'd7)
                            state <= RX_STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (baud_cnt == CNT_W'(CLOCKS_PER_BAUD - 1)) begin
                        baud_cnt <= '0;
                        state    <= RX_IDLE;
                        if (rx_sync) begin
                            data_o  <= shift;
                            valid_o <= 1'b1;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/receive_keypoints.sv
// Host-to-BRAM loader: pairs UART bytes (upper first) into words and writes them sequentially.
module receive_keypoints
    import keypoint_pkg::*;
#(
    parameter int BRAM_LENGTH     = 1000,
    parameter int BIT_DEPTH       = 13,
    parameter int CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD,
    parameter int TIMEOUT_CLKS    = 20 * CLOCKS_PER_BAUD
) (
    input  logic                           clk,
    input  logic                           rst_in,
    input  logic                           rx,
    input  logic                           start,
    output logic [$clog2(BRAM_LENGTH)-1:0] address,
    output logic [BIT_DEPTH-1:0]           data,
    output logic                           we,
    output logic                           busy,
    output logic                           done,
    output logic                           resync,
    output logic [1:0]                     out_state
);

    localparam int ADDR_W  = $clog2(BRAM_LENGTH);
    localparam int UPPER_W = BIT_DEPTH - 8;
    localparam int TO_W    = $clog2(TIMEOUT_CLKS + 1);

    kp_state_t          state;
    logic [UPPER_W-1:0] upper;
    logic [TO_W-1:0]    timeout_cnt;
    logic [7:0]         byte_data;
    logic               byte_valid;
    logic               byte_err;

    uart_rx #(
        .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
    ) u_rx (
        .clk    (clk),
        .rst_in (rst_in),
        .rx     (rx),
        .data_o (byte_data),
        .valid_o(byte_valid),
        .err_o  (byte_err)
    );

    assign out_state = state;

    // Only the low UPPER_W bits of the upper byte are kept; the rest never reach the word.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            address     <= '0;
            data        <= '0;
            we          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            resync      <= 1'b0;
            upper       <= '0;
            timeout_cnt <= '0;
        end else begin
            we     <= 1'b0;
            done   <= 1'b0;
            resync <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= WAIT_UPPER;
                        address <= '0;
                        busy    <= 1'b1;
                    end
                end
                WAIT_UPPER: begin
                    if (byte_valid) begin
                        upper       <= byte_data[UPPER_W-1:0];
                        timeout_cnt <= '0;
                        state       <= WAIT_LOWER;
                    end
                end
                // A valid lower byte beats a same-cycle timeout or error.
                WAIT_LOWER: begin
                    if (byte_valid) begin
                        data  <= {upper, byte_data};
                        we    <= 1'b1;
                        state <= WRITE;
                    end else if (byte_err || timeout_cnt == TO_W'(TIMEOUT_CLKS - 1)) begin
                        upper       <= '0;
                        timeout_cnt <= '0;
                        resync      <= 1'b1;
                        state       <= WAIT_UPPER;
                    end else begin
                        timeout_cnt <= timeout_cnt + TO_W'(1);
                    end
                end
                WRITE: begin
                    if (address == ADDR_W'(BRAM_LENGTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        address <= address + ADDR_W'(1);
                        state   <= WAIT_UPPER;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_receive_keypoints.sv
// Directed bench for receive_keypoints: framed bytes in, BRAM writes and strobes checked.
module tb_receive_keypoints;

    localparam int BRAM_LENGTH     = 4;
    localparam int BIT_DEPTH       = 13;
    localparam int CLOCKS_PER_BAUD = 32;
    localparam int TIMEOUT_CLKS    = 20 * CLOCKS_PER_BAUD;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        rx = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  address;
    logic [12:0] data;
    logic        we;
    logic        busy;
    logic        done;
    logic        resync;
    logic [1:0]  out_state;

    int vectors = 0;
    int miscompares = 0;

    int          cycle = 0;
    logic [1:0]  we_addr[$];
    logic [12:0] we_data[$];
    int          last_we_cycle = 0;
    int          done_cycle = 0;
    int          done_cnt = 0;
    int          resync_cnt = 0;
    int          valid_cnt = 0;
    int          err_cnt = 0;

    receive_keypoints #(
        .BRAM_LENGTH    (BRAM_LENGTH),
        .BIT_DEPTH      (BIT_DEPTH),
        .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD),
        .TIMEOUT_CLKS   (TIMEOUT_CLKS)
    ) dut (
        .clk      (clk),
        .rst_in   (rst_in),
        .rx       (rx),
        .start    (start),
        .address  (address),
        .data     (data),
        .we       (we),
        .busy     (busy),
        .done     (done),
        .resync   (resync),
        .out_state(out_state)
    );

    always #5 clk = ~clk;

    // Record every write and strobe seen at the falling edge.
    always @(negedge clk) begin
        cycle = cycle + 1;
        if (we) begin
            we_addr.push_back(address);
            we_data.push_back(data);
            last_we_cycle = cycle;
        end
        if (done) begin
            done_cnt   = done_cnt + 1;
            done_cycle = cycle;
        end
        if (resync)            resync_cnt = resync_cnt + 1;
        if (dut.u_rx.valid_o)  valid_cnt  = valid_cnt + 1;
        if (dut.u_rx.err_o)    err_cnt    = err_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors = vectors + 1;
        if (observed !== expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkWrite(input string tag, input int idx, input logic [1:0] exp_addr, input logic [12:0] exp_data);
        logic [31:0] obs_a;
        logic [31:0] obs_d;
        obs_a = (idx < we_addr.size()) ? {30'd0, we_addr[idx]} : 32'hDEAD;
        obs_d = (idx < we_data.size()) ? {19'd0, we_data[idx]} : 32'hDEAD;
        checkOutput({tag, "_addr"}, obs_a, {30'd0, exp_addr});
        checkOutput({tag, "_data"}, obs_d, {19'd0, exp_data});
    endtask

    // One 8N1 frame followed by one idle bit; stop_bit=0 forces a framing error.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        @(negedge clk) rx = 1'b0;
        repeat (CLOCKS_PER_BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLOCKS_PER_BAUD) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CLOCKS_PER_BAUD) @(negedge clk);
        rx = 1'b1;
        repeat (CLOCKS_PER_BAUD) @(negedge clk);
    endtask

    task automatic doReset();
        rst_in = 1'b1;
        rx     = 1'b1;
        start  = 1'b0;
        repeat (3) @(negedge clk);
        rst_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulseStart();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    int base_we;
    int base_rs;
    int base_v;
    int base_e;

    initial begin
        $display("[TB] receive_keypoints bench start");
        doReset();
        checkOutput("rst_address", {30'd0, address}, 32'd0);
        checkOutput("rst_data", {19'd0, data}, 32'd0);
        checkOutput("rst_we", {31'd0, we}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_resync", {31'd0, resync}, 32'd0);
        checkOutput("rst_state", {30'd0, out_state}, 32'd0);

        // Full transfer of four words.
        base_we = we_addr.size();
        pulseStart();
        checkOutput("arm_busy", {31'd0, busy}, 32'd1);
        checkOutput("arm_state", {30'd0, out_state}, 32'd1);
        applyStimulus(8'h1F, 1'b1); applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h00, 1'b1); applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h0A, 1'b1); applyStimulus(8'hBC, 1'b1);
        applyStimulus(8'h12, 1'b1); applyStimulus(8'h34, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("full_we_count", we_addr.size() - base_we, 32'd4);
        checkWrite("full_w0", base_we + 0, 2'd0, 13'h1FFF);
        checkWrite("full_w1", base_we + 1, 2'd1, 13'h0001);
        checkWrite("full_w2", base_we + 2, 2'd2, 13'h0ABC);
        checkWrite("full_w3", base_we + 3, 2'd3, 13'h1234);
        checkOutput("full_done_count", done_cnt, 32'd1);
        checkOutput("full_done_delay", done_cycle - last_we_cycle, 32'd1);
        checkOutput("full_busy_end", {31'd0, busy}, 32'd0);
        checkOutput("full_state_end", {30'd0, out_state}, 32'd0);

        // Lower byte never arrives: timeout resync, then a fresh pair at address 0.
        doReset();
        base_we = we_addr.size();
        base_rs = resync_cnt;
        pulseStart();
        applyStimulus(8'h05, 1'b1);
        repeat (TIMEOUT_CLKS + 100) @(negedge clk);
        checkOutput("to_resync", resync_cnt - base_rs, 32'd1);
        checkOutput("to_no_we", we_addr.size() - base_we, 32'd0);
        checkOutput("to_state", {30'd0, out_state}, 32'd1);
        applyStimulus(8'h01, 1'b1); applyStimulus(8'h02, 1'b1);
        repeat (5) @(negedge clk);
        checkWrite("to_w0", base_we, 2'd0, 13'h0102);
        checkOutput("to_busy", {31'd0, busy}, 32'd1);

        // Framing error on the lower byte discards the partial word.
        doReset();
        base_we = we_addr.size();
        base_rs = resync_cnt;
        pulseStart();
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'hAA, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("fe_no_we", we_addr.size() - base_we, 32'd0);
        checkOutput("fe_resync", resync_cnt - base_rs, 32'd1);
        applyStimulus(8'h00, 1'b1); applyStimulus(8'h07, 1'b1);
        repeat (5) @(negedge clk);
        checkWrite("fe_w0", base_we, 2'd0, 13'h0007);

        // Bytes before arming are dropped; masked upper bits 7:5 of 0xE1 vanish.
        doReset();
        base_we = we_addr.size();
        applyStimulus(8'h11, 1'b1); applyStimulus(8'h22, 1'b1);
        repeat (5) @(negedge clk);
        checkOutput("pre_no_we", we_addr.size() - base_we, 32'd0);
        checkOutput("pre_busy", {31'd0, busy}, 32'd0);
        checkOutput("pre_state", {30'd0, out_state}, 32'd0);
        pulseStart();
        applyStimulus(8'hE1, 1'b1); applyStimulus(8'h23, 1'b1);
        repeat (5) @(negedge clk);
        checkWrite("pre_w0", base_we, 2'd0, 13'h0123);

        // Asynchronous reset while a lower byte is on the wire.
        doReset();
        pulseStart();
        applyStimulus(8'h00, 1'b1); applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h00, 1'b1); applyStimulus(8'h22, 1'b1);
        applyStimulus(8'h00, 1'b1);
        checkOutput("ar_pre_addr", {30'd0, address}, 32'd2);
        @(negedge clk) rx = 1'b0;
        repeat (CLOCKS_PER_BAUD + 3 * CLOCKS_PER_BAUD) @(negedge clk);
        @(posedge clk);
        #3 rst_in = 1'b1;
        #1;
        checkOutput("ar_address", {30'd0, address}, 32'd0);
        checkOutput("ar_data", {19'd0, data}, 32'd0);
        checkOutput("ar_busy", {31'd0, busy}, 32'd0);
        checkOutput("ar_we", {31'd0, we}, 32'd0);
        checkOutput("ar_state", {30'd0, out_state}, 32'd0);
        rx = 1'b1;
        base_we = we_addr.size();
        repeat (3) @(negedge clk);
        rst_in = 1'b0;
        repeat (12 * CLOCKS_PER_BAUD) @(negedge clk);
        checkOutput("ar_no_we", we_addr.size() - base_we, 32'd0);
        pulseStart();
        applyStimulus(8'h0A, 1'b1); applyStimulus(8'hBC, 1'b1);
        repeat (5) @(negedge clk);
        checkWrite("ar_w0", base_we, 2'd0, 13'h0ABC);

        // Short low glitch while idle must not start a frame.
        doReset();
        base_v = valid_cnt;
        base_e = err_cnt;
        @(negedge clk) rx = 1'b0;
        #100 rx = 1'b1;
        repeat (12 * CLOCKS_PER_BAUD) @(negedge clk);
        checkOutput("gl_no_valid", valid_cnt - base_v, 32'd0);
        checkOutput("gl_no_err", err_cnt - base_e, 32'd0);
        checkOutput("gl_state", {30'd0, out_state}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
